arith_unit_seq: RTL and testbench

- Parametrised, registered successor to the 8-bit ripple arithmetic unit.
- Performs the same four add-based ops (A+B, A+~B, A, A+all-ones, each plus carry-in) over WIDTH bits, adds an iterative unsigned multiply, and registers results behind valid/ready handshakes.
- Sits between the operand register file and the writeback/flag register of the datapath.

---
 rtl/arith_unit_pkg.sv | 10 +
 rtl/arith_unit_seq_if.sv | 23 ++
 rtl/arith_core.sv | 25 ++
 rtl/arith_unit_seq.sv | 131 +++++++++++++
 tb/tb_arith_unit_seq.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arith_unit_pkg.sv
// Shared op codes and FSM state type for the registered arithmetic unit.
package arith_unit_pkg;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUBB = 3'b001;
    localparam logic [2:0] OP_TFR  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;

    typedef enum logic {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;
endpackage

// File: rtl/arith_unit_seq_if.sv
// Operand/result handshake bundle between the register file, the unit and writeback.
interface arith_unit_seq_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] d_hi;
    logic             c_out;
    logic             z;
    logic             v;
    logic             n;
    logic             err;

    modport master (output in_valid, op, a, b, c_in, out_ready,
                    input  in_ready, out_valid, d, d_hi, c_out, z, v, n, err);
    modport slave  (input  in_valid, op, a, b, c_in, out_ready,
                    output in_ready, out_valid, d, d_hi, c_out, z, v, n, err);
endinterface

// File: rtl/arith_core.sv
// Combinational Y-select plus WIDTH-bit adder; shared by single-cycle ops and the MUL accumulate.
module arith_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             v
);
    logic [WIDTH-1:0] y;

    always_comb begin
        case (op)
            2'b00:   y = b;
            2'b01:   y = ~b;
            2'b10:   y = '0;
            default: y = '1;
        endcase
        {c_out, sum} = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, c_in};
        v = (a[WIDTH-1] == y[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
    end
endmodule

// File: rtl/arith_unit_seq.sv
// Registered add-based ALU with iterative shift-add multiply behind valid/ready.
// Optional unsigned saturation of ADD/SUBB when ARITH_UNIT_SAT_EN is defined.
module arith_unit_seq
    import arith_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    arith_unit_seq_if.slave bus
);
    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand, mplier, acc;
    logic [CNT_W-1:0]   cnt;
    logic               accept, mul_last;
    logic [WIDTH-1:0]   core_a, core_b, core_sum, d_sat;
    logic [1:0]         core_op;
    logic               core_cin, core_c, core_v;
    logic [2*WIDTH-1:0] prod_nxt;

    arith_core #(.WIDTH(WIDTH)) u_core (
        .a(core_a), .b(core_b), .op(core_op), .c_in(core_cin),
        .sum(core_sum), .c_out(core_c), .v(core_v)
    );

    assign accept   = bus.in_valid & bus.in_ready;
    assign mul_last = (cnt == CNT_W'(WIDTH - 1));
    // {acc, mplier} shifted right by one with the accumulate carry entering at the top
    assign prod_nxt = {core_c, core_sum, mplier[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && bus.op == OP_MUL) state_nxt = MUL_RUN;
            MUL_RUN: if (mul_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state == IDLE) & (!bus.out_valid | bus.out_ready);
        core_a   = bus.a;
        core_b   = bus.b;
        core_op  = bus.op[1:0];
        core_cin = bus.c_in;
        if (state == MUL_RUN) begin
            core_a   = acc;
            core_b   = mplier[0] ? mcand : '0;
            core_op  = OP_ADD[1:0];
            core_cin = 1'b0;
        end
    end

    always_comb begin
        d_sat = core_sum;
`ifdef ARITH_UNIT_SAT_EN
        if (bus.op == OP_ADD && core_c)        d_sat = '1;
        else if (bus.op == OP_SUBB && !core_c) d_sat = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.d     <= '0;
            bus.d_hi  <= '0;
            bus.c_out <= 1'b0;
            bus.z     <= 1'b0;
            bus.v     <= 1'b0;
            bus.n     <= 1'b0;
            bus.err   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                case (bus.op)
                    OP_ADD, OP_SUBB, OP_TFR, OP_DEC: begin
                        bus.d     <= d_sat;
                        bus.d_hi  <= '0;
                        bus.c_out <= core_c;
                        bus.z     <= (core_sum == '0);
                        bus.v     <= core_v;
                        bus.n     <= d_sat[WIDTH-1];
                        bus.err   <= 1'b0;
                        bus.out_valid <= 1'b1;
                    end
                    OP_MUL: begin
                        mcand  <= bus.a;
                        mplier <= bus.b;
                        acc    <= '0;
                        cnt    <= '0;
                        bus.out_valid <= 1'b0;
                    end
                    default: begin
                        bus.d     <= bus.a;
                        bus.d_hi  <= '0;
                        bus.c_out <= 1'b0;
                        bus.z     <= (bus.a == '0);
                        bus.v     <= 1'b0;
                        bus.n     <= bus.a[WIDTH-1];
                        bus.err   <= 1'b1;
                        bus.out_valid <= 1'b1;
                    end
                endcase
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end else begin
            {acc, mplier} <= prod_nxt;
            cnt <= cnt + CNT_W'(1);
            if (mul_last) begin
                bus.d     <= prod_nxt[WIDTH-1:0];
                bus.d_hi  <= prod_nxt[2*WIDTH-1:WIDTH];
                bus.c_out <= 1'b0;
                bus.z     <= (prod_nxt == '0);
                bus.v     <= (prod_nxt[2*WIDTH-1:WIDTH] != '0);
                bus.n     <= prod_nxt[WIDTH-1];
                bus.err   <= 1'b0;
                bus.out_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_arith_unit_seq.sv
// Self-checking bench for arith_unit_seq (WIDTH=8): vector table, hand sequences, random vs model.
module tb_arith_unit_seq;
    import arith_unit_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arith_unit_seq_if #(.WIDTH(W)) bus ();
    arith_unit_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] d_hi;
        logic       c;
        logic       z;
        logic       v;
        logic       n;
        logic       err;
    } res_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        res_t       exp;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic res_t sample();
        return {bus.d, bus.d_hi, bus.c_out, bus.z, bus.v, bus.n, bus.err};
    endfunction

    function automatic res_t mkr(logic [7:0] d, logic [7:0] hi, logic c, logic z, logic v, logic n, logic e);
        return {d, hi, c, z, v, n, e};
    endfunction

    function automatic vec_t mkv(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic cin, res_t exp);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.cin = cin; t.exp = exp;
        return t;
    endfunction

    // Reference: plain integer arithmetic on unsigned/signed values.
    function automatic res_t model(logic [2:0] op, logic [7:0] a, logic [7:0] b, logic cin);
        res_t r;
        int ua, ub, y, s, sa, sy, ss, p;
        r  = '0;
        ua = int'(a);
        ub = int'(b);
        if (op == 3'd4) begin
            p      = ua * ub;
            r.d    = 8'(p % 256);
            r.d_hi = 8'(p / 256);
            r.z    = (p == 0);
            r.v    = (p > 255);
            r.n    = r.d[7];
        end else if (op > 3'd4) begin
            r.d   = a;
            r.z   = (ua == 0);
            r.n   = a[7];
            r.err = 1'b1;
        end else begin
            case (op)
                3'd0:    y = ub;
                3'd1:    y = 255 - ub;
                3'd2:    y = 0;
                default: y = 255;
            endcase
            s   = ua + y + int'(cin);
            r.d = 8'(s % 256);
            r.c = (s > 255);
            r.z = ((s % 256) == 0);
            sa  = (ua > 127) ? ua - 256 : ua;
            sy  = (y > 127) ? y - 256 : y;
            ss  = sa + sy + int'(cin);
            r.v = (ss > 127) || (ss < -128);
`ifdef ARITH_UNIT_SAT_EN
            if (op == 3'd0 && r.c)  r.d = 8'hFF;
            if (op == 3'd1 && !r.c) r.d = 8'h00;
`endif
            r.n = r.d[7];
        end
        return r;
    endfunction

    task automatic chk_res(input string name, input res_t act, input res_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got d=%h d_hi=%h c=%b z=%b v=%b n=%b err=%b, want d=%h d_hi=%h c=%b z=%b v=%b n=%b err=%b",
                     name, act.d, act.d_hi, act.c, act.z, act.v, act.n, act.err,
                     exp.d, exp.d_hi, exp.c, exp.z, exp.v, exp.n, exp.err);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    // Issue one op with out_ready held high; return the result and accept-to-out_valid latency.
    task automatic exec(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, output res_t r, output int lat);
        int g;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.c_in = cin;
        bus.out_ready = 1'b1;
        #1;
        g = 0;
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: in_ready got 0, want 1");
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r = sample();
    endtask

    vec_t tbl[10];
    res_t r, e;
    res_t q[$];
    int   lat, busy, seen;

    initial begin
        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        bus.out_ready = 1'b0;

        tbl[0] = mkv(OP_ADD,  8'h7F, 8'h01, 1'b0, mkr(8'h80, 8'h00, 0, 0, 1, 1, 0));
        tbl[1] = mkv(OP_SUBB, 8'h05, 8'h05, 1'b1, mkr(8'h00, 8'h00, 1, 1, 0, 0, 0));
`ifdef ARITH_UNIT_SAT_EN
        tbl[2] = mkv(OP_SUBB, 8'h03, 8'h05, 1'b1, mkr(8'h00, 8'h00, 0, 0, 0, 0, 0));
        tbl[4] = mkv(OP_ADD,  8'hFF, 8'h01, 1'b0, mkr(8'hFF, 8'h00, 1, 1, 0, 1, 0));
`else
        tbl[2] = mkv(OP_SUBB, 8'h03, 8'h05, 1'b1, mkr(8'hFE, 8'h00, 0, 0, 0, 1, 0));
        tbl[4] = mkv(OP_ADD,  8'hFF, 8'h01, 1'b0, mkr(8'h00, 8'h00, 1, 1, 0, 0, 0));
`endif
        tbl[3] = mkv(OP_DEC,  8'h00, 8'h9C, 1'b0, mkr(8'hFF, 8'h00, 0, 0, 0, 1, 0));
        tbl[5] = mkv(OP_MUL,  8'hFF, 8'hFF, 1'b1, mkr(8'h01, 8'hFE, 0, 0, 1, 0, 0));
        tbl[6] = mkv(OP_MUL,  8'h00, 8'h37, 1'b0, mkr(8'h00, 8'h00, 0, 1, 0, 0, 0));
        tbl[7] = mkv(OP_TFR,  8'h80, 8'h55, 1'b1, mkr(8'h81, 8'h00, 0, 0, 0, 1, 0));
        tbl[8] = mkv(3'b110,  8'h5A, 8'h33, 1'b1, mkr(8'h5A, 8'h00, 0, 0, 0, 0, 1));
        tbl[9] = mkv(OP_ADD,  8'h7F, 8'h7F, 1'b1, mkr(8'hFF, 8'h00, 0, 0, 1, 1, 0));

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_res("reset_outs", sample(), '0);
        chk_bit("reset_out_valid", bus.out_valid, 1'b0);
        chk_bit("reset_in_ready", bus.in_ready, 1'b1);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            exec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, r, lat);
            chk_res($sformatf("tbl%0d", i), r, tbl[i].exp);
            chk_int($sformatf("tbl%0d_latency", i), lat, (tbl[i].op == OP_MUL) ? 9 : 1);
        end

        // MUL occupancy: in_ready low for exactly WIDTH cycles, result on cycle 9
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = OP_MUL; bus.a = 8'hFF; bus.b = 8'hFF; bus.out_ready = 1'b1;
        @(posedge clk);
        busy = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            if (!bus.in_ready) busy++;
        end
        chk_int("mul_busy_cycles", busy, 8);
        chk_bit("mul_out_valid_c9", bus.out_valid, 1'b1);
        chk_res("mul_ff_ff", sample(), model(OP_MUL, 8'hFF, 8'hFF, 1'b0));

        // Backpressure: result held while out_ready low
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = OP_ADD; bus.a = 8'h10; bus.b = 8'h20; bus.c_in = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        e = model(OP_ADD, 8'h10, 8'h20, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk_res($sformatf("hold%0d", k), sample(), e);
            chk_bit($sformatf("hold%0d_valid", k), bus.out_valid, 1'b1);
            chk_bit($sformatf("hold%0d_in_ready", k), bus.in_ready, 1'b0);
            @(negedge clk);
        end
        bus.in_valid = 1'b1; bus.op = OP_ADD; bus.a = 8'h01; bus.b = 8'h02; bus.out_ready = 1'b1;
        #1;
        chk_bit("release_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk_bit("replace_valid", bus.out_valid, 1'b1);
        chk_res("replace_result", sample(), model(OP_ADD, 8'h01, 8'h02, 1'b0));
        @(negedge clk);
        chk_bit("drain_valid", bus.out_valid, 1'b0);

        // Back-to-back single-cycle ops at full rate
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) begin
                chk_bit($sformatf("b2b%0d_valid", i), bus.out_valid, 1'b1);
                chk_res($sformatf("b2b%0d", i), sample(), q.pop_front());
            end
            if (i < 6) begin
                bus.in_valid = 1'b1;
                bus.op   = 3'($urandom_range(0, 3));
                bus.a    = 8'($urandom);
                bus.b    = 8'($urandom);
                bus.c_in = 1'($urandom);
                q.push_back(model(bus.op, bus.a, bus.b, bus.c_in));
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end

        // Reset during MUL step 4 discards the op
        bus.in_valid = 1'b1; bus.op = OP_MUL; bus.a = 8'h12; bus.b = 8'h34;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_res("midmul_rst_outs", sample(), '0);
        chk_bit("midmul_rst_valid", bus.out_valid, 1'b0);
        chk_bit("midmul_rst_in_ready", bus.in_ready, 1'b1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk_int("midmul_no_output", seen, 0);

        // Random ops against the model
        for (int i = 0; i < 60; i++) begin
            logic [2:0] rop;
            logic [7:0] ra, rb;
            logic       rc;
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rc  = 1'($urandom);
            exec(rop, ra, rb, rc, r, lat);
            chk_res($sformatf("rnd%0d op=%0d a=%h b=%h c=%b", i, rop, ra, rb, rc), r, model(rop, ra, rb, rc));
            chk_int($sformatf("rnd%0d_latency", i), lat, (rop == OP_MUL) ? 9 : 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
